// File: rtl/core_pkg.sv
// core_pkg: shared register-file sizing constants for the core.
package core_pkg;
    localparam int XLEN     = 32;
    localparam int REG_NUM  = 32;
    localparam int REG_AW   = $clog2(REG_NUM);
    localparam int REG_ZERO = 0;
endpackage

// File: rtl/regfile_sb.sv
// regfile_sb: per-register busy scoreboard, set at issue and cleared at writeback.
// o_busy_nxt exposes the post-update bits so the read path can bypass them.
import core_pkg::*;

module regfile_sb #(
    parameter int NREGS = REG_NUM,
    parameter int NWR   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_set_en,
    input  logic [AW-1:0]     i_set_addr,
    input  logic [NWR-1:0]    i_wr_en,
    input  logic [NWR*AW-1:0] i_wr_addr,
    output logic [NREGS-1:0]  o_busy_nxt,
    output logic [NREGS-1:0]  o_busy_vec
);
    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_nxt;

    // Set is applied after the clears so the newer producer keeps ownership.
    always_comb begin
        w_nxt = r_busy;
        for (int k = 0; k < NWR; k++)
            if (i_wr_en[k]) w_nxt[i_wr_addr[k*AW +: AW]] = 1'b0;
        if (i_set_en) w_nxt[i_set_addr] = 1'b1;
        w_nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk)
        r_busy <= rst ? '0 : w_nxt;

    assign o_busy_nxt = w_nxt;
    assign o_busy_vec = r_busy;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with x0 hard-wired to zero and a busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data and busy clears to reads.
import core_pkg::*;

module regfile_mp #(
    parameter int XLEN  = core_pkg::XLEN,
    parameter int NREGS = REG_NUM,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_wdata,
    input  logic [NRD*AW-1:0]   rd_addr,
    input  logic                rd_hold,
    output logic [NRD*XLEN-1:0] rd_rdata,
    output logic [NRD-1:0]      rd_busy,
    input  logic                sb_set_en,
    input  logic [AW-1:0]       sb_set_addr,
    output logic [NREGS-1:0]    sb_busy_vec
);
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [XLEN-1:0]  r_rdata [NRD];
    logic [NRD-1:0]   r_rbusy;
    logic [XLEN-1:0]  w_rd [NRD];
    logic [NRD-1:0]   w_bz;
    logic [NREGS-1:0] w_busy_nxt;

    regfile_sb #(.NREGS(NREGS), .NWR(NWR), .AW(AW)) u_sb (
        .clk        (clk),
        .rst        (rst),
        .i_set_en   (sb_set_en),
        .i_set_addr (sb_set_addr),
        .i_wr_en    (wr_en),
        .i_wr_addr  (wr_addr),
        .o_busy_nxt (w_busy_nxt),
        .o_busy_vec (sb_busy_vec)
    );

    // Ascending port order makes the highest-index writer win on conflicts.
    always_ff @(posedge clk)
        if (rst)
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        else
            for (int k = 0; k < NWR; k++)
                if (wr_en[k] && wr_addr[k*AW +: AW] != AW'(REG_ZERO))
                    r_regs[wr_addr[k*AW +: AW]] <= wr_wdata[k*XLEN +: XLEN];

    always_comb begin
        for (int j = 0; j < NRD; j++) begin
            w_rd[j] = r_regs[rd_addr[j*AW +: AW]];
            w_bz[j] = BYPASS ? w_busy_nxt[rd_addr[j*AW +: AW]] : sb_busy_vec[rd_addr[j*AW +: AW]];
            for (int k = 0; k < NWR; k++)
                if (BYPASS && wr_en[k] && wr_addr[k*AW +: AW] == rd_addr[j*AW +: AW])
                    w_rd[j] = wr_wdata[k*XLEN +: XLEN];
            if (rd_addr[j*AW +: AW] == AW'(REG_ZERO)) w_rd[j] = '0;
        end
    end

    always_ff @(posedge clk)
        if (rst) begin
            for (int j = 0; j < NRD; j++) r_rdata[j] <= '0;
            r_rbusy <= '0;
        end else if (!rd_hold) begin
            for (int j = 0; j < NRD; j++) r_rdata[j] <= w_rd[j];
            r_rbusy <= w_bz;
        end

    for (genvar j = 0; j < NRD; j++) begin : g_rd
        assign rd_rdata[j*XLEN +: XLEN] = r_rdata[j];
    end
    assign rd_busy = r_rbusy;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of regfile_mp (2 read, 2 write ports, 32x32).
// Expectations follow REGFILE_BYPASS_EN when it is defined for the build.
module tb_regfile_mp;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_wdata;
    logic [9:0]  rd_addr;
    logic        rd_hold;
    logic [63:0] rd_rdata;
    logic [1:0]  rd_busy;
    logic        sb_set_en;
    logic [4:0]  sb_set_addr;
    logic [31:0] sb_busy_vec;
    int          n_tot = 0;
    int          n_bad = 0;

    regfile_mp dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_wdata    (wr_wdata),
        .rd_addr     (rd_addr),
        .rd_hold     (rd_hold),
        .rd_rdata    (rd_rdata),
        .rd_busy     (rd_busy),
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sb_set_addr),
        .sb_busy_vec (sb_busy_vec)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 2'b11; wr_addr = {5'd2, 5'd1};
        wr_wdata = {32'h0000_0002, 32'h0000_0001};
        rd_addr = {5'd2, 5'd1}; rd_hold = 1'b1; sb_set_en = 1'b1; sb_set_addr = 5'd4;
        tick;
        chk("rst_rd0", rd_rdata[31:0], 32'h0);
        chk("rst_rd1", rd_rdata[63:32], 32'h0);
        chk("rst_busy", {30'h0, rd_busy}, 32'h0);
        chk("rst_sb", sb_busy_vec, 32'h0);
        rst = 1'b0; wr_en = 2'b00; rd_hold = 1'b0; sb_set_en = 1'b0;
        tick;
        chk("rst_x1_unwritten", rd_rdata[31:0], 32'h0);
        chk("rst_x2_unwritten", rd_rdata[63:32], 32'h0);
        // write conflict on x5
        wr_en = 2'b11; wr_addr = {5'd5, 5'd5}; wr_wdata = {32'h2222_2222, 32'h1111_1111};
        tick;
        wr_en = 2'b00; rd_addr = {5'd5, 5'd5};
        tick;
        chk("conflict_rd0", rd_rdata[31:0], 32'h2222_2222);
        chk("conflict_rd1", rd_rdata[63:32], 32'h2222_2222);
        // x0 protection
        wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_wdata = {32'h0, 32'hDEAD_BEEF};
        sb_set_en = 1'b1; sb_set_addr = 5'd0;
        tick;
        wr_en = 2'b00; sb_set_en = 1'b0; rd_addr = {5'd0, 5'd0};
        tick;
        chk("x0_rd0", rd_rdata[31:0], 32'h0);
        chk("x0_rd1", rd_rdata[63:32], 32'h0);
        chk("x0_busy", {30'h0, rd_busy}, 32'h0);
        chk("x0_sb", sb_busy_vec, 32'h0);
        // same-cycle write and read of x7
        wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_wdata = {32'h0, 32'h1234_5678};
        tick;
        wr_wdata = {32'h0, 32'hA5A5_A5A5}; rd_addr = {5'd0, 5'd7};
        tick;
        chk("x7_same_cycle", rd_rdata[31:0], BYP ? 32'hA5A5_A5A5 : 32'h1234_5678);
        wr_en = 2'b00;
        tick;
        chk("x7_after", rd_rdata[31:0], 32'hA5A5_A5A5);
        // scoreboard on x3
        rd_addr = {5'd3, 5'd3}; sb_set_en = 1'b1; sb_set_addr = 5'd3;
        tick;
        sb_set_en = 1'b0;
        chk("sb_set_vec", sb_busy_vec, 32'h0000_0008);
        chk("sb_set_rd_same", {30'h0, rd_busy}, BYP ? 32'h3 : 32'h0);
        tick;
        chk("sb_set_rd", {30'h0, rd_busy}, 32'h3);
        wr_en = 2'b10; wr_addr = {5'd3, 5'd0}; wr_wdata = {32'h0000_0033, 32'h0};
        tick;
        wr_en = 2'b00;
        chk("sb_clr_vec", sb_busy_vec, 32'h0);
        chk("sb_clr_rd_same", {30'h0, rd_busy}, BYP ? 32'h0 : 32'h3);
        chk("sb_clr_data", rd_rdata[63:32], BYP ? 32'h0000_0033 : 32'h0);
        tick;
        chk("sb_clr_rd", {30'h0, rd_busy}, 32'h0);
        sb_set_en = 1'b1; wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_wdata = {32'h0, 32'h0000_0034};
        tick;
        sb_set_en = 1'b0; wr_en = 2'b00;
        chk("sb_both_vec", sb_busy_vec, 32'h0000_0008);
        chk("sb_both_rd_same", {30'h0, rd_busy}, BYP ? 32'h3 : 32'h0);
        tick;
        chk("sb_both_rd", {30'h0, rd_busy}, 32'h3);
        chk("sb_both_data", rd_rdata[31:0], 32'h0000_0034);
        wr_en = 2'b01;
        tick;
        wr_en = 2'b00;
        chk("sb_final_vec", sb_busy_vec, 32'h0);
        // hold while x9 is written
        rd_addr = {5'd5, 5'd9};
        tick;
        chk("hold_pre", rd_rdata[31:0], 32'h0);
        rd_hold = 1'b1; wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_wdata = {32'h0, 32'hCAFE_F00D};
        rd_addr = {5'd9, 5'd9};
        tick;
        wr_en = 2'b00;
        chk("hold_c1", rd_rdata[31:0], 32'h0);
        chk("hold_c1_p1", rd_rdata[63:32], 32'h2222_2222);
        tick;
        chk("hold_c2", rd_rdata[31:0], 32'h0);
        tick;
        chk("hold_c3", rd_rdata[31:0], 32'h0);
        rd_hold = 1'b0;
        tick;
        chk("hold_release", rd_rdata[31:0], 32'hCAFE_F00D);
        chk("hold_release_p1", rd_rdata[63:32], 32'hCAFE_F00D);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
